// File: rtl/axi4s_wrr_scheduler_if.sv
// Bundled AXI4-S signals for the weighted round-robin scheduler: N input
// streams (packed per stream) on one side, a single output stream on the other.
interface axi4s_wrr_scheduler_if #(
   parameter int nr_of_streams_p = 4,
   parameter int tdata_width_p   = 4,
   parameter int tid_bit_width_p = $clog2(nr_of_streams_p)
);
   logic [nr_of_streams_p-1:0]                        axi4s_i_tready;
   logic [nr_of_streams_p-1:0]                        axi4s_i_tvalid;
   logic [nr_of_streams_p-1:0]                        axi4s_i_tlast;
   logic [nr_of_streams_p-1:0][tdata_width_p*8-1:0]   axi4s_i_tdata;
   logic                                              axi4s_o_tready;
   logic                                              axi4s_o_tvalid;
   logic                                              axi4s_o_tlast;
   logic [tid_bit_width_p-1:0]                        axi4s_o_tid;
   logic [tdata_width_p*8-1:0]                        axi4s_o_tdata;

   modport slave (
      input  axi4s_i_tvalid, axi4s_i_tlast, axi4s_i_tdata, axi4s_o_tready,
      output axi4s_i_tready, axi4s_o_tvalid, axi4s_o_tlast, axi4s_o_tid, axi4s_o_tdata
   );

   modport master (
      output axi4s_i_tvalid, axi4s_i_tlast, axi4s_i_tdata, axi4s_o_tready,
      input  axi4s_i_tready, axi4s_o_tvalid, axi4s_o_tlast, axi4s_o_tid, axi4s_o_tdata
   );
endinterface

// File: rtl/axi4s_wrr_scheduler.sv
// Packet-granular weighted round-robin arbiter: a registered grant steers a
// combinational pass-through from one of N AXI4-S inputs to the shared output.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_ARB  | search from ptr for a requesting, enabled stream; no beats move
// ST_XFER | granted stream owns the output until credit runs out or it idles
//         | at a packet boundary
module axi4s_wrr_scheduler #(
   parameter int nr_of_streams_p = 4,
   parameter int tdata_width_p   = 4,
   parameter int weight_width_p  = 4,
   parameter int tid_bit_width_p = $clog2(nr_of_streams_p)
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic [nr_of_streams_p*weight_width_p-1:0]  cfg_weight,
   axi4s_wrr_scheduler_if.slave                       axi4s,
   output logic                                       grant_active,
   output logic [tid_bit_width_p-1:0]                 grant_id
);
   localparam int N  = nr_of_streams_p;
   localparam int W  = weight_width_p;
   localparam int TW = tid_bit_width_p;
   localparam int DW = tdata_width_p * 8;

   typedef enum logic {ST_ARB = 1'b0, ST_XFER = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   ptr_q, ptr_d;
   logic [TW-1:0]   grant_q, grant_d;
   logic [W-1:0]    credit_q, credit_d;
   logic            mid_pkt_q, mid_pkt_d;

   logic [W-1:0]    weight_a [N];
   logic            found;
   logic [TW-1:0]   found_idx;
   logic [TW:0]     sum;
   logic [TW-1:0]   next_ptr;
   logic            sel_valid, sel_last, beat;
   logic [N-1:0]    tready_v;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         weight_a[i] = cfg_weight[i*W +: W];
      end
   end

   // Rotating priority search starting at ptr, wrapping modulo N.
   always_comb begin
      found     = 1'b0;
      found_idx = '0;
      sum       = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_q} + (TW+1)'(k);
         if (sum >= (TW+1)'(N)) begin
            sum = sum - (TW+1)'(N);
         end
         if (!found && axi4s.axi4s_i_tvalid[sum[TW-1:0]] && (weight_a[sum[TW-1:0]] != '0)) begin
            found     = 1'b1;
            found_idx = sum[TW-1:0];
         end
      end
   end

   assign grant_active = (state_q == ST_XFER);
   assign grant_id     = grant_q;
   assign sel_valid    = axi4s.axi4s_i_tvalid[grant_q];
   assign sel_last     = axi4s.axi4s_i_tlast[grant_q];
   assign beat         = grant_active & sel_valid & axi4s.axi4s_o_tready;
   assign next_ptr     = (grant_q == TW'(N-1)) ? '0 : grant_q + TW'(1);

   always_comb begin
      tready_v          = '0;
      tready_v[grant_q] = grant_active & axi4s.axi4s_o_tready;
   end

   assign axi4s.axi4s_i_tready = tready_v;
   assign axi4s.axi4s_o_tvalid = grant_active & sel_valid;
   assign axi4s.axi4s_o_tlast  = grant_active & sel_last;
   assign axi4s.axi4s_o_tid    = grant_q;
   assign axi4s.axi4s_o_tdata  = grant_active ? axi4s.axi4s_i_tdata[grant_q] : {DW{1'b0}};

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      credit_d  = credit_q;
      mid_pkt_d = mid_pkt_q;
      case (state_q)
         ST_ARB: begin
            if (found) begin
               grant_d   = found_idx;
               credit_d  = weight_a[found_idx];
               mid_pkt_d = 1'b0;
               state_d   = ST_XFER;
            end
         end
         ST_XFER: begin
            if (beat) begin
               if (sel_last) begin
                  mid_pkt_d = 1'b0;
                  credit_d  = credit_q - W'(1);
                  if (credit_q == W'(1)) begin
                     ptr_d   = next_ptr;
                     state_d = ST_ARB;
                  end
               end else begin
                  mid_pkt_d = 1'b1;
               end
            end else if (!mid_pkt_q && !sel_valid) begin
               // Idle at a packet boundary: release the grant, drop leftover credit.
               ptr_d   = next_ptr;
               state_d = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ARB;
         ptr_q     <= '0;
         grant_q   <= '0;
         credit_q  <= '0;
         mid_pkt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         credit_q  <= credit_d;
         mid_pkt_q <= mid_pkt_d;
      end
   end
endmodule

// File: tb/tb_axi4s_wrr_scheduler.sv
// Scoreboard bench for axi4s_wrr_scheduler: per-stream beat queues drive the
// inputs, the expected output order is queued by hand, a monitor pops and compares.
module tb_axi4s_wrr_scheduler;
   localparam int N  = 4;
   localparam int DB = 4;
   localparam int W  = 4;
   localparam int TW = 2;

   typedef struct {logic [31:0] data; logic last; int gap;} beat_t;
   typedef struct {logic [TW-1:0] tid; logic [31:0] data; logic last;} exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N*W-1:0]  cfg_weight;
   logic            grant_active;
   logic [TW-1:0]   grant_id;

   axi4s_wrr_scheduler_if #(.nr_of_streams_p(N), .tdata_width_p(DB), .tid_bit_width_p(TW)) bus ();

   axi4s_wrr_scheduler #(
      .nr_of_streams_p(N), .tdata_width_p(DB), .weight_width_p(W), .tid_bit_width_p(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_weight(cfg_weight), .axi4s(bus.slave),
      .grant_active(grant_active), .grant_id(grant_id)
   );

   beat_t      src_q [N][$];
   int         gap_cnt [N];
   exp_t       exp_q [$];
   int         checks = 0, errors = 0;
   int         beat_cnt = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
   logic [N-1:0] tready_seen, fire;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] dv(int t, int s, int p, int b);
      return {8'(t), 8'(s), 8'(p), 8'(b)};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic load(int s, logic [31:0] d, logic l, int g);
      beat_t b;
      b.data = d; b.last = l; b.gap = g;
      src_q[s].push_back(b);
   endtask

   task automatic push_exp(int t, logic [31:0] d, logic l);
      exp_t e;
      e.tid = TW'(t); e.data = d; e.last = l;
      exp_q.push_back(e);
   endtask

   task automatic clear_sources();
      for (int s = 0; s < N; s++) begin
         src_q[s].delete();
         gap_cnt[s] = 0;
         bus.axi4s_i_tvalid[s] = 1'b0;
         bus.axi4s_i_tlast[s]  = 1'b0;
         bus.axi4s_i_tdata[s]  = '0;
      end
   endtask

   task automatic assert_rst();
      @(posedge clk); #2;
      rst_n = 1'b0;
      clear_sources();
   endtask

   task automatic release_rst();
      @(negedge clk);
      beat_cnt = 0; first_cyc = -1; last_cyc = -1; tready_seen = '0;
      rst_n = 1'b1;
   endtask

   task automatic wait_drain(int budget);
      int n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (exp_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: %0d beats still outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (8) @(negedge clk);
      #1;
   endtask

   // Source driver: handshake sampled mid-cycle, next beat presented after the edge.
   initial begin
      beat_t b;
      forever begin
         @(negedge clk);
         fire = bus.axi4s_i_tready & bus.axi4s_i_tvalid;
         @(posedge clk); #1;
         for (int s = 0; s < N; s++) begin
            if (fire[s] && src_q[s].size() > 0) begin
               b = src_q[s].pop_front();
               if (src_q[s].size() > 0) gap_cnt[s] = src_q[s][0].gap;
            end
            if (src_q[s].size() == 0) begin
               bus.axi4s_i_tvalid[s] = 1'b0; bus.axi4s_i_tlast[s] = 1'b0; bus.axi4s_i_tdata[s] = '0;
            end else if (gap_cnt[s] > 0) begin
               bus.axi4s_i_tvalid[s] = 1'b0; bus.axi4s_i_tlast[s] = 1'b0;
               gap_cnt[s]--;
            end else begin
               bus.axi4s_i_tvalid[s] = 1'b1;
               bus.axi4s_i_tlast[s]  = src_q[s][0].last;
               bus.axi4s_i_tdata[s]  = src_q[s][0].data;
            end
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            tready_seen |= bus.axi4s_i_tready;
            if (bus.axi4s_o_tvalid && bus.axi4s_o_tready) begin
               beat_cnt++;
               if (first_cyc < 0) first_cyc = cyc;
               last_cyc = cyc;
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_beat: got tid=%0d data=%h last=%b, required no beat",
                           bus.axi4s_o_tid, bus.axi4s_o_tdata, bus.axi4s_o_tlast);
               end else begin
                  e = exp_q.pop_front();
                  check("beat_tid",  64'(bus.axi4s_o_tid),   64'(e.tid));
                  check("beat_data", 64'(bus.axi4s_o_tdata), 64'(e.data));
                  check("beat_last", 64'(bus.axi4s_o_tlast), 64'(e.last));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt [N];
      int seq [6];
      int n;
      rst_n = 1'b0;
      cfg_weight = '0;
      bus.axi4s_o_tready = 1'b1;
      clear_sources();

      // T1: equal weights, 2-beat packets, strict rotation with one bubble per grant
      cfg_weight = 16'h1111;
      for (int p = 0; p < 3; p++) begin
         for (int s = 0; s < N; s++) begin
            load(s, dv(1, s, p, 0), 1'b0, 0);
            load(s, dv(1, s, p, 1), 1'b1, 0);
            push_exp(s, dv(1, s, p, 0), 1'b0);
            push_exp(s, dv(1, s, p, 1), 1'b1);
         end
      end
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", 64'({bus.axi4s_i_tready, bus.axi4s_o_tvalid, bus.axi4s_o_tlast,
                                  bus.axi4s_o_tid, bus.axi4s_o_tdata, grant_active, grant_id}), 64'd0);
      release_rst();
      wait_drain(300);
      check("t1_span_cycles", 64'(last_cyc - first_cyc), 64'd34);

      // T2: weights {3,1,0,2}, saturating 1-beat packets
      assert_rst();
      cfg_weight = 16'h2013;
      for (int p = 0; p < 6; p++) load(0, dv(2, 0, p, 0), 1'b1, 0);
      for (int p = 0; p < 2; p++) load(1, dv(2, 1, p, 0), 1'b1, 0);
      for (int p = 0; p < 4; p++) load(2, dv(2, 2, p, 0), 1'b1, 0);
      for (int p = 0; p < 4; p++) load(3, dv(2, 3, p, 0), 1'b1, 0);
      seq = '{0, 0, 0, 1, 3, 3};
      cnt = '{0, 0, 0, 0};
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 6; i++) begin
            push_exp(seq[i], dv(2, seq[i], cnt[seq[i]], 0), 1'b1);
            cnt[seq[i]]++;
         end
      end
      release_rst();
      wait_drain(300);
      check("t2_stream2_tready_seen", 64'(tready_seen[2]), 64'd0);
      check("t2_stream2_beats_left", 64'(src_q[2].size()), 64'd4);

      // T3: stream 1 stalls mid-packet; others must not cut in
      assert_rst();
      cfg_weight = 16'h1111;
      load(0, dv(3, 0, 0, 0), 1'b1, 0);
      load(1, dv(3, 1, 0, 0), 1'b0, 0);
      load(1, dv(3, 1, 0, 1), 1'b0, 0);
      load(1, dv(3, 1, 0, 2), 1'b0, 5);
      load(1, dv(3, 1, 0, 3), 1'b1, 0);
      load(2, dv(3, 2, 0, 0), 1'b1, 0);
      push_exp(0, dv(3, 0, 0, 0), 1'b1);
      for (int b = 0; b < 4; b++) push_exp(1, dv(3, 1, 0, b), (b == 3));
      push_exp(2, dv(3, 2, 0, 0), 1'b1);
      release_rst();
      wait_drain(300);

      // T4: downstream backpressure for 10 cycles mid-packet
      assert_rst();
      cfg_weight = 16'h0001;
      for (int b = 0; b < 4; b++) begin
         load(0, dv(4, 0, 0, b), (b == 3), 0);
         push_exp(0, dv(4, 0, 0, b), (b == 3));
      end
      release_rst();
      n = 0;
      while (beat_cnt < 2 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      check("t4_reached_beat2", 64'(beat_cnt), 64'd2);
      @(posedge clk); #2;
      bus.axi4s_o_tready = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("t4_stall_hold", 64'({bus.axi4s_o_tvalid, grant_active, grant_id, bus.axi4s_i_tready, bus.axi4s_o_tdata}),
               64'({1'b1, 1'b1, 2'd0, 4'b0000, dv(4, 0, 0, 2)}));
      end
      @(posedge clk); #2;
      bus.axi4s_o_tready = 1'b1;
      wait_drain(100);

      // T5: weight 4 on stream 0, which idles after one packet -> give-up to stream 1
      assert_rst();
      cfg_weight = 16'h0014;
      load(0, dv(5, 0, 0, 0), 1'b0, 0);
      load(0, dv(5, 0, 0, 1), 1'b1, 0);
      load(0, dv(5, 0, 1, 0), 1'b1, 3);
      load(1, dv(5, 1, 0, 0), 1'b1, 0);
      push_exp(0, dv(5, 0, 0, 0), 1'b0);
      push_exp(0, dv(5, 0, 0, 1), 1'b1);
      push_exp(1, dv(5, 1, 0, 0), 1'b1);
      push_exp(0, dv(5, 0, 1, 0), 1'b1);
      release_rst();
      wait_drain(200);

      // T6: reset during beat 2 of a 5-beat packet, ptr must return to 0
      assert_rst();
      cfg_weight = 16'h1111;
      load(0, dv(6, 0, 0, 0), 1'b1, 0);
      for (int b = 0; b < 5; b++) load(1, dv(6, 1, 0, b), (b == 4), 0);
      push_exp(0, dv(6, 0, 0, 0), 1'b1);
      push_exp(1, dv(6, 1, 0, 0), 1'b0);
      push_exp(1, dv(6, 1, 0, 1), 1'b0);
      release_rst();
      n = 0;
      while (beat_cnt < 3 && n < 100) begin
         @(negedge clk); #2;
         n++;
      end
      check("t6_reached_beat2", 64'(beat_cnt), 64'd3);
      rst_n = 1'b0;
      #1;
      check("t6_async_reset_outputs", 64'({bus.axi4s_i_tready, bus.axi4s_o_tvalid, bus.axi4s_o_tlast,
                                           bus.axi4s_o_tdata, grant_active, grant_id}), 64'd0);
      clear_sources();
      @(posedge clk); #2;
      load(2, dv(6, 2, 1, 0), 1'b1, 0);
      load(0, dv(6, 0, 1, 0), 1'b1, 0);
      push_exp(0, dv(6, 0, 1, 0), 1'b1);
      push_exp(2, dv(6, 2, 1, 0), 1'b1);
      repeat (2) @(posedge clk);
      release_rst();
      wait_drain(200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
